// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between a core's instruction-fetch and data ports.
// Fixed data priority with fetch anti-starvation, plus a sticky bus-timeout flag.
module mem_port_arbiter #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic                  if_req,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_ack,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  input  logic                  dm_we,
  input  logic                  dm_req,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  dm_ack,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  output logic                  bus_we,
  output logic                  bus_req,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  input  logic                  bus_ack,
  output logic                  grant_dm,
  output logic                  timeout_err,
  input  logic                  clear_err
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  localparam logic [15:0] WaitLast  = 16'(TIMEOUT - 1);
  localparam logic [3:0]  StarveMax = 4'(STARVE_LIMIT);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
  logic                  bus_we_q, bus_we_d;
  logic                  bus_req_q, bus_req_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
  logic                  if_ack_q, if_ack_d;
  logic                  dm_ack_q, dm_ack_d;
  logic                  grant_dm_q, grant_dm_d;
  logic                  timeout_err_q, timeout_err_d;
  logic [3:0]            starve_cnt_q, starve_cnt_d;
  logic [15:0]           wait_cnt_q, wait_cnt_d;
  logic                  pick_dm;

  always_comb begin
    state_d       = state_q;
    bus_addr_d    = bus_addr_q;
    bus_wdata_d   = bus_wdata_q;
    bus_we_d      = bus_we_q;
    bus_req_d     = bus_req_q;
    if_rdata_d    = if_rdata_q;
    dm_rdata_d    = dm_rdata_q;
    if_ack_d      = 1'b0;
    dm_ack_d      = 1'b0;
    grant_dm_d    = grant_dm_q;
    starve_cnt_d  = starve_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = clear_err ? 1'b0 : timeout_err_q;
    pick_dm       = dm_req && !(if_req && (starve_cnt_q >= StarveMax));

    case (state_q)
      StIdle: begin
        wait_cnt_d = 16'd0;
        if (if_req || dm_req) begin
          bus_req_d  = 1'b1;
          grant_dm_d = pick_dm;
          state_d    = StBusy;
          if (pick_dm) begin
            bus_addr_d  = dm_addr;
            bus_wdata_d = dm_wdata;
            bus_we_d    = dm_we;
            if (if_req && (starve_cnt_q < StarveMax)) starve_cnt_d = starve_cnt_q + 4'd1;
          end else begin
            bus_addr_d   = if_addr;
            bus_wdata_d  = '0;
            bus_we_d     = 1'b0;
            starve_cnt_d = 4'd0;
          end
        end
      end
      StBusy: begin
        if (bus_ack) begin
          bus_req_d = 1'b0;
          state_d   = StResp;
          if (grant_dm_q) begin
            if (!bus_we_q) dm_rdata_d = bus_rdata;
            dm_ack_d = 1'b1;
          end else begin
            if_rdata_d = bus_rdata;
            if_ack_d   = 1'b1;
          end
        end else if (wait_cnt_q == WaitLast) begin
          // Abort: owner sees a zero-data ack and the error flag latches (set beats clear).
          bus_req_d     = 1'b0;
          timeout_err_d = 1'b1;
          state_d       = StResp;
          if (grant_dm_q) begin
            dm_rdata_d = '0;
            dm_ack_d   = 1'b1;
          end else begin
            if_rdata_d = '0;
            if_ack_d   = 1'b1;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      bus_addr_q    <= '0;
      bus_wdata_q   <= '0;
      bus_we_q      <= 1'b0;
      bus_req_q     <= 1'b0;
      if_rdata_q    <= '0;
      dm_rdata_q    <= '0;
      if_ack_q      <= 1'b0;
      dm_ack_q      <= 1'b0;
      grant_dm_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      starve_cnt_q  <= 4'd0;
      wait_cnt_q    <= 16'd0;
    end else begin
      state_q       <= state_d;
      bus_addr_q    <= bus_addr_d;
      bus_wdata_q   <= bus_wdata_d;
      bus_we_q      <= bus_we_d;
      bus_req_q     <= bus_req_d;
      if_rdata_q    <= if_rdata_d;
      dm_rdata_q    <= dm_rdata_d;
      if_ack_q      <= if_ack_d;
      dm_ack_q      <= dm_ack_d;
      grant_dm_q    <= grant_dm_d;
      timeout_err_q <= timeout_err_d;
      starve_cnt_q  <= starve_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  assign bus_addr    = bus_addr_q;
  assign bus_wdata   = bus_wdata_q;
  assign bus_we      = bus_we_q;
  assign bus_req     = bus_req_q;
  assign if_rdata    = if_rdata_q;
  assign dm_rdata    = dm_rdata_q;
  assign if_ack      = if_ack_q;
  assign dm_ack      = dm_ack_q;
  assign grant_dm    = grant_dm_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one task per scenario, inline checks.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_addr, dm_addr, dm_wdata, bus_rdata;
  logic        if_req, dm_req, dm_we, bus_ack, clear_err;
  logic [31:0] if_rdata, dm_rdata, bus_addr, bus_wdata;
  logic        if_ack, dm_ack, bus_we, bus_req, grant_dm, timeout_err;

  int checks = 0;
  int passes = 0;

  mem_port_arbiter #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .STARVE_LIMIT(4), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .if_addr(if_addr), .if_req(if_req), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_req(dm_req),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_req(bus_req),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .grant_dm(grant_dm), .timeout_err(timeout_err), .clear_err(clear_err)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle; inputs are driven and outputs sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if ({bus_req, bus_we, if_ack, dm_ack, grant_dm, timeout_err} !== 6'b0) begin
      $display("FAIL reset_flags: got %b required 000000",
               {bus_req, bus_we, if_ack, dm_ack, grant_dm, timeout_err});
    end else passes++;
    checks++;
    if ({bus_addr, bus_wdata, if_rdata, dm_rdata} !== 128'd0) begin
      $display("FAIL reset_data: got %h %h %h %h required zeros",
               bus_addr, bus_wdata, if_rdata, dm_rdata);
    end else passes++;
  endtask

  task automatic test_if_read();
    if_req = 1'b1; if_addr = 32'h100;
    step();
    checks++;
    if ({bus_req, bus_we, grant_dm, bus_addr} !== {3'b100, 32'h100}) begin
      $display("FAIL if_read_grant: got req=%b we=%b gdm=%b addr=%h required 1 0 0 00000100",
               bus_req, bus_we, grant_dm, bus_addr);
    end else passes++;
    bus_ack = 1'b1; bus_rdata = 32'hA5A5A5A5; if_req = 1'b0;
    step();
    bus_ack = 1'b0;
    checks++;
    if ({if_ack, dm_ack, bus_req, if_rdata} !== {3'b100, 32'hA5A5A5A5}) begin
      $display("FAIL if_read_ack: got ia=%b da=%b req=%b rdata=%h required 1 0 0 a5a5a5a5",
               if_ack, dm_ack, bus_req, if_rdata);
    end else passes++;
    step();
    checks++;
    if ({if_ack, dm_ack} !== 2'b00) begin
      $display("FAIL if_read_pulse: got ia=%b da=%b required 0 0", if_ack, dm_ack);
    end else passes++;
  endtask

  task automatic test_dm_write();
    // Load dm_rdata with a known value first so "unchanged" is meaningful.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h1F0;
    step();
    bus_ack = 1'b1; bus_rdata = 32'hCAFE0001; dm_req = 1'b0;
    step();
    bus_ack = 1'b0;
    checks++;
    if ({dm_ack, dm_rdata} !== {1'b1, 32'hCAFE0001}) begin
      $display("FAIL dm_read: got ack=%b rdata=%h required 1 cafe0001", dm_ack, dm_rdata);
    end else passes++;
    step();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'h12345678;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 0) begin dm_req = 1'b0; dm_we = 1'b0; dm_wdata = 32'h0; end
      if (i == 3) begin bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF; end
      checks++;
      if ({bus_req, bus_we, grant_dm, dm_ack, bus_addr, bus_wdata} !==
          {4'b1110, 32'h200, 32'h12345678}) begin
        $display("FAIL dm_write_stable[%0d]: got req=%b we=%b gdm=%b ack=%b a=%h d=%h", i,
                 bus_req, bus_we, grant_dm, dm_ack, bus_addr, bus_wdata);
      end else passes++;
    end
    step();
    bus_ack = 1'b0;
    checks++;
    if ({dm_ack, bus_req, dm_rdata} !== {2'b10, 32'hCAFE0001}) begin
      $display("FAIL dm_write_ack: got ack=%b req=%b rdata=%h required 1 0 cafe0001",
               dm_ack, bus_req, dm_rdata);
    end else passes++;
    step();
  endtask

  task automatic test_contention();
    logic [5:0] exp_gdm;
    exp_gdm = 6'b101111;  // index 0 first: DM, DM, DM, DM, IF, DM
    if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0;
    if_addr = 32'h300; dm_addr = 32'h400;
    bus_ack = 1'b1; bus_rdata = 32'h11111111;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if ({bus_req, grant_dm, bus_addr} !==
          {1'b1, exp_gdm[i], (exp_gdm[i] ? 32'h400 : 32'h300)}) begin
        $display("FAIL contention_grant[%0d]: got req=%b gdm=%b addr=%h required gdm=%b", i,
                 bus_req, grant_dm, bus_addr, exp_gdm[i]);
      end else passes++;
      step();
      checks++;
      if ({dm_ack, if_ack} !== {exp_gdm[i], ~exp_gdm[i]}) begin
        $display("FAIL contention_ack[%0d]: got da=%b ia=%b required da=%b", i,
                 dm_ack, if_ack, exp_gdm[i]);
      end else passes++;
      if (i == 5) begin if_req = 1'b0; dm_req = 1'b0; bus_ack = 1'b0; end
      step();
    end
  endtask

  task automatic test_timeout();
    if_req = 1'b1; if_addr = 32'h500;
    step();
    if_req = 1'b0;
    for (int i = 1; i < 8; i++) begin
      step();
      checks++;
      if ({bus_req, if_ack, timeout_err} !== 3'b100) begin
        $display("FAIL timeout_wait[%0d]: got req=%b ack=%b err=%b required 1 0 0", i,
                 bus_req, if_ack, timeout_err);
      end else passes++;
    end
    step();
    checks++;
    if ({bus_req, if_ack, timeout_err, if_rdata} !== {3'b011, 32'h0}) begin
      $display("FAIL timeout_fire: got req=%b ack=%b err=%b rdata=%h required 0 1 1 0",
               bus_req, if_ack, timeout_err, if_rdata);
    end else passes++;
    step();
    step();
    checks++;
    if ({if_ack, timeout_err} !== 2'b01) begin
      $display("FAIL timeout_sticky: got ack=%b err=%b required 0 1", if_ack, timeout_err);
    end else passes++;
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    checks++;
    if (timeout_err !== 1'b0) begin
      $display("FAIL timeout_clear: got err=%b required 0", timeout_err);
    end else passes++;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h510;
    step();
    bus_ack = 1'b1; bus_rdata = 32'h00000077; dm_req = 1'b0;
    step();
    bus_ack = 1'b0;
    checks++;
    if ({dm_ack, timeout_err, dm_rdata} !== {2'b10, 32'h77}) begin
      $display("FAIL timeout_next: got ack=%b err=%b rdata=%h required 1 0 00000077",
               dm_ack, timeout_err, dm_rdata);
    end else passes++;
    step();
  endtask

  task automatic test_reset_busy();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h600;
    step();
    step();
    step();
    checks++;
    if ({bus_req, grant_dm} !== 2'b11) begin
      $display("FAIL rst_busy_pre: got req=%b gdm=%b required 1 1", bus_req, grant_dm);
    end else passes++;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus_req, dm_ack, grant_dm, bus_addr, dm_rdata} !== {3'b000, 64'd0}) begin
      $display("FAIL rst_busy_async: got req=%b ack=%b gdm=%b addr=%h rdata=%h required zeros",
               bus_req, dm_ack, grant_dm, bus_addr, dm_rdata);
    end else passes++;
    dm_req = 1'b0;
    step();
    rst = 1'b0;
    step();
    checks++;
    if ({dm_ack, if_ack, bus_req} !== 3'b000) begin
      $display("FAIL rst_busy_noack: got da=%b ia=%b req=%b required 0 0 0",
               dm_ack, if_ack, bus_req);
    end else passes++;
    if_req = 1'b1; if_addr = 32'h700;
    step();
    bus_ack = 1'b1; bus_rdata = 32'h0000BEEF; if_req = 1'b0;
    step();
    bus_ack = 1'b0;
    checks++;
    if ({if_ack, dm_ack, if_rdata} !== {2'b10, 32'hBEEF}) begin
      $display("FAIL rst_busy_after: got ia=%b da=%b rdata=%h required 1 0 0000beef",
               if_ack, dm_ack, if_rdata);
    end else passes++;
    step();
  endtask

  task automatic test_simultaneous();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h800;
    step();
    dm_req = 1'b0;
    step();
    step();
    bus_ack = 1'b1; bus_rdata = 32'h0F0F0F0F;
    step();
    bus_ack = 1'b0;
    checks++;
    if ({dm_ack, dm_rdata} !== {1'b1, 32'h0F0F0F0F}) begin
      $display("FAIL withdraw_ack: got ack=%b rdata=%h required 1 0f0f0f0f", dm_ack, dm_rdata);
    end else passes++;
    step();
    if_req = 1'b1; if_addr = 32'h900;
    step();
    if_req = 1'b0;
    for (int i = 1; i < 8; i++) step();
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    checks++;
    if ({if_ack, timeout_err} !== 2'b11) begin
      $display("FAIL set_beats_clear: got ack=%b err=%b required 1 1", if_ack, timeout_err);
    end else passes++;
    step();
  endtask

  initial begin
    rst = 1'b1;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; bus_rdata = '0;
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; bus_ack = 1'b0; clear_err = 1'b0;
    step();
    test_reset();
    rst = 1'b0;
    step();
    test_if_read();
    test_dm_write();
    test_contention();
    test_timeout();
    test_reset_busy();
    test_simultaneous();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single shared memory bus between a CPU core's instruction-fetch port and its data-memory port. Both ports use the core's req/ack handshake. The block registers the winning request, holds it on the bus until the bus acknowledges, and returns read data with a one-cycle ack pulse. It sits between one `cpu_core` instance and the memory subsystem, and provides fixed data priority, instruction-fetch anti-starvation and a bus timeout.

## Interface
Parameters:
- `DATA_WIDTH`, 32: data bus width.
- `ADDR_WIDTH`, 32: address width.
- `STARVE_LIMIT`, 4: consecutive lost arbitrations after which IF wins over DM; range 1–15.
- `TIMEOUT`, 255: bus cycles without `bus_ack` before the transaction is aborted; range 1–65535.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `if_addr` in ADDR_WIDTH: fetch address.
- `if_req` in 1: fetch request (read only).
- `if_rdata` out DATA_WIDTH: fetch data.
- `if_ack` out 1: fetch done, one-cycle pulse.
- `dm_addr` in ADDR_WIDTH: data address.
- `dm_wdata` in DATA_WIDTH: write data.
- `dm_we` in 1: 1 = write.
- `dm_req` in 1: data request.
- `dm_rdata` out DATA_WIDTH: read data.
- `dm_ack` out 1: data done, one-cycle pulse.
- `bus_addr` out ADDR_WIDTH: shared bus address.
- `bus_wdata` out DATA_WIDTH: shared bus write data.
- `bus_we` out 1: shared bus write enable.
- `bus_req` out 1: shared bus request.
- `bus_rdata` in DATA_WIDTH: bus read data.
- `bus_ack` in 1: bus completion.
- `grant_dm` out 1: current or last owner; 1 = DM, 0 = IF.
- `timeout_err` out 1: sticky; set on any bus timeout.
- `clear_err` in 1: synchronous clear of `timeout_err`.

## Operation
- **States:** IDLE, BUSY, RESP.
- **IDLE: arbitration.** When `if_req` or `dm_req` is sampled high, one requester is granted:
  - Only one requesting: that one wins.
  - Both requesting: DM wins, unless `starve_cnt >= STARVE_LIMIT`, in which case IF wins.
  - On grant:
    - The winner's addr, wdata and we are registered onto `bus_*` (IF grant forces `bus_we=0`, `bus_wdata=0`).
    - `bus_req` is set to 1, `grant_dm` is updated and the state moves to BUSY.
- **BUSY: bus transaction.**
  - `bus_req` and all `bus_*` outputs stay stable until `bus_ack` is sampled high.
  - At that edge:
    - `bus_req` is set to 0.
    - On a read, the owner's rdata register is loaded with `bus_rdata`. On a DM write, `dm_rdata` is left unchanged.
    - The owner's ack is set to 1 and the state moves to RESP.
  - A 16-bit `wait_cnt` counts BUSY cycles. When `wait_cnt == TIMEOUT-1` and `bus_ack` is low:
    - `bus_req` is set to 0, the owner's rdata is set to 0, the owner's ack is set to 1 and `timeout_err` is set to 1.
    - The state moves to RESP.
- **RESP:** the ack is high for exactly this one cycle. No arbitration happens in RESP. The state moves to IDLE next. Requesters must drop or change req by the end of the ack cycle.
- **starve_cnt (4-bit, saturating at STARVE_LIMIT):**
  - +1 on each DM grant made while `if_req` is high.
  - Cleared on each IF grant.
  - Unchanged otherwise.
- **Requester withdrawal:** if a requester drops req during BUSY, the transaction still completes and the ack is still pulsed.
- **`clear_err`:** clears `timeout_err` at the next edge. If a timeout fires in the same cycle, set wins.
- **`bus_ack` outside BUSY** is ignored.

## Timing
- **Reset values:** state IDLE; `bus_req`, `bus_we`, `if_ack`, `dm_ack`, `grant_dm`, `timeout_err` = 0; `bus_addr`, `bus_wdata`, `if_rdata`, `dm_rdata` = 0; `starve_cnt` and `wait_cnt` = 0.
- **Reset mid-transaction:** `bus_req` drops immediately (asynchronously). No ack is issued for the aborted transaction.
- **Latency:**
  - req sampled at edge 0 → `bus_req` high after edge 0.
  - `bus_ack` sampled at edge k → xx_ack high from edge k to edge k+1.
  - Back in IDLE at edge k+1. Zero-wait bus: ack 2 cycles after req. Minimum 3 cycles per transaction.
- **Timeout:** ack is asserted TIMEOUT cycles after `bus_req` rises.
- **Rdata hold:** rdata outputs hold their value until that owner's next completed read.

## Test plan
- **Single IF read.** `if_req=1`, `if_addr=0x100`; bus acks 1 cycle after `bus_req` with `0xA5A5A5A5`. Required: `bus_addr=0x100`, `bus_we=0`, one `if_ack` pulse with `if_rdata=0xA5A5A5A5` on cycle 2, `dm_ack` never asserted.
- **DM write.** `dm_req=1`, `dm_we=1`, addr `0x200`, wdata `0x12345678`; bus acks after 3 wait cycles. Required: bus signals stable for 4 cycles, one `dm_ack` pulse, `dm_rdata` unchanged.
- **Contention and anti-starvation.** `if_req` and `dm_req` held high continuously with STARVE_LIMIT=4. Required grant sequence DM, DM, DM, DM, IF, DM, …; `grant_dm` matches.
- **Timeout.** TIMEOUT=8, `bus_ack` held low. Required: ack 8 cycles after `bus_req` rises, rdata=0, `timeout_err=1` until `clear_err` is pulsed. Next transaction proceeds normally.
- **Reset during BUSY.** Assert `rst` 2 cycles into a DM read. Required: `bus_req=0` immediately, no ack, all outputs at reset values. After release, a new IF read completes normally.
- **Withdrawal and simultaneous events.** Drop `dm_req` mid-BUSY → `dm_ack` still pulses. `clear_err` in the same cycle as a timeout → `timeout_err=1`.
